// File: rtl/count8_ld.sv
// Loadable up-counter with carry-out, cascadable into wider synchronous counters.
// Latency: one clock for count/load/reset; co is combinational from ci and q.
// Backpressure: none; ci acts as the count enable and the block always accepts it.
module count8_ld #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             ci,
  input  logic             ld,
  output logic [WIDTH-1:0] q,
  output logic             co
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next-state selection: load beats count beats hold; reset is applied in the register.
  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = d;
    end else if (ci) begin
      // Natural modulo wrap: all-ones plus one truncates to zero.
      q_d = q_q + ONE;
    end
  end

  // Counter register with synchronous reset; no power-up value is assumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= ZERO;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

  // Carry depends only on the registered count and ci, so a chain of instances
  // (co -> ci) ripples the enable combinationally within one cycle.
  assign co = ci & (q_q == ALL_ONES);

endmodule

// File: tb/tb_count8_ld.sv
module tb_count8_ld;

  logic       clk;
  logic       rst;
  logic [7:0] d;
  logic       ci;
  logic       ld;
  logic [7:0] q;
  logic       co;

  int tests_run;
  int tests_failed;

  count8_ld #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .ci  (ci),
    .ld  (ld),
    .q   (q),
    .co  (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_q(input string tag, input logic [7:0] exp);
    tests_run++;
    assert (q === exp) else begin
      tests_failed++;
      $error("FAIL %s: q=%h expected %h", tag, q, exp);
    end
  endtask

  task automatic chk_co(input string tag, input logic exp);
    tests_run++;
    assert (co === exp) else begin
      tests_failed++;
      $error("FAIL %s: co=%b expected %b", tag, co, exp);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // Reset for two edges with junk on d.
    rst = 1'b1; ci = 1'b0; ld = 1'b0; d = 8'hFE;
    tick(); tick();
    chk_q("reset_q", 8'h00);
    chk_co("reset_co", 1'b0);

    // Count three edges from zero.
    rst = 1'b0; ci = 1'b1;
    tick(); chk_q("count1", 8'h01); chk_co("count1_co", 1'b0);
    tick(); chk_q("count2", 8'h02); chk_co("count2_co", 1'b0);
    tick(); chk_q("count3", 8'h03); chk_co("count3_co", 1'b0);

    // Reset mid-count with ci high, then resume with no dead cycle.
    rst = 1'b1;
    tick(); chk_q("rst_midcount", 8'h00); chk_co("rst_midcount_co", 1'b0);
    tick(); chk_q("rst_hold_ci", 8'h00);
    rst = 1'b0;
    tick(); chk_q("rst_release", 8'h01);

    // Load FE, count to FF (carry asserted combinationally), wrap to 00.
    ld = 1'b1; ci = 1'b0; d = 8'hFE;
    tick(); chk_q("load_fe", 8'hFE); chk_co("load_fe_co", 1'b0);
    ld = 1'b0; ci = 1'b1;
    tick(); chk_q("inc_ff", 8'hFF); chk_co("inc_ff_co", 1'b1);
    tick(); chk_q("wrap", 8'h00); chk_co("wrap_co", 1'b0);

    // Load dominates count.
    ld = 1'b1; ci = 1'b1; d = 8'hFE;
    tick(); chk_q("ld_dom1", 8'hFE); chk_co("ld_dom1_co", 1'b0);
    tick(); chk_q("ld_dom2", 8'hFE);
    tick(); chk_q("ld_dom3", 8'hFE); chk_co("ld_dom3_co", 1'b0);

    // Load FF, hold with ci low, then raise ci with no edge.
    d = 8'hFF; ci = 1'b0;
    tick(); chk_q("load_ff", 8'hFF); chk_co("load_ff_co_ci0", 1'b0);
    ld = 1'b0;
    tick(); chk_q("hold_ff", 8'hFF); chk_co("hold_ff_co", 1'b0);
    tick(); chk_q("hold_ff2", 8'hFF);
    #1 ci = 1'b1;
    #1 chk_co("ci_rise_co", 1'b1);
    chk_q("ci_rise_q", 8'hFF);

    // co ignores ld, rst and d.
    ld = 1'b1; d = 8'h00;
    #1 chk_co("co_ignores_ld", 1'b1);
    rst = 1'b1;
    #1 chk_co("co_ignores_rst", 1'b1);
    ci = 1'b0;
    #1 chk_co("co_ci_gate", 1'b0);

    // Reset while loading clears rather than loading.
    ld = 1'b1; d = 8'h55; ci = 1'b1;
    tick(); chk_q("rst_over_ld", 8'h00); chk_co("rst_over_ld_co", 1'b0);

    // Release reset straight into a load.
    rst = 1'b0;
    tick(); chk_q("ld_after_rst", 8'h55);

    // Arbitrary load then count, then reset mid-count.
    d = 8'hA7; ci = 1'b0;
    tick(); chk_q("load_a7", 8'hA7);
    ld = 1'b0; ci = 1'b1;
    tick(); chk_q("inc_a8", 8'hA8);
    tick(); chk_q("inc_a9", 8'hA9);
    ci = 1'b0;
    tick(); chk_q("hold_a9", 8'hA9);
    rst = 1'b1; ci = 1'b1;
    tick(); chk_q("rst_a9", 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: sequence did not complete");
    $fatal(1, "timeout");
  end

endmodule
